// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame decoder:
//   - state_t    : frame assembly state (IDLE, CMD, LEN, DATA, CHK, DONE)
//   - err_code_t : error reason reported alongside err_pulse
//   - SYNC_BYTE_DEFAULT : default frame start marker
//   - in_frame() : true for states where the inter-byte timeout runs
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      LEN  = 3'd2,
      DATA = 3'd3,
      CHK  = 3'd4,
      DONE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_BAD_LEN = 2'd0,
      ERR_BAD_CHK = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_OVERRUN = 2'd3
   } err_code_t;

   // A frame is "in flight" between the SYNC byte and the checksum byte;
   // only then does silence on the line count towards a timeout.
   function automatic logic in_frame(input state_t s);
      return (s == CMD) || (s == LEN) || (s == DATA) || (s == CHK);
   endfunction

endpackage

// File: rtl/uart_payload_ram.sv
// -----------------------------------------------------------------------------
// uart_payload_ram
// Payload buffer: DEPTH x 8 bits, one synchronous write port and one
// registered read port (1-cycle read latency). Storage is not reset; only the
// read register clears on reset so the visible output starts at zero.
//
// Ports:
//   i_clk      : clock
//   i_reset    : synchronous active-high reset (read register only)
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address, sampled every clock
//   o_rd_data  : mem[i_rd_addr] from the previous clock
// -----------------------------------------------------------------------------
module uart_payload_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   input  logic [AW-1:0] i_rd_addr,
   output logic [7:0]    o_rd_data
);

   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder
// Assembles the UART receiver byte stream into frames of the form
//   SYNC, CMD, LEN, LEN payload bytes, CHK
// where CHK is the XOR of CMD, LEN and every payload byte. A good frame is
// held on frame_valid until frame_ack; the payload is read through a
// registered read port. Malformed, timed-out and overrun traffic produces a
// one-cycle err_pulse with err_code.
//
// Handshake: rx_ready is a one-cycle strobe qualifying rx_data. frame_valid
// stays high (with frame_cmd/frame_len stable) until a cycle where
// frame_ack=1; frame_ack is ignored while frame_valid=0.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   rx_data       : received byte, valid when rx_ready=1
//   rx_ready      : byte strobe
//   frame_valid   : good frame pending
//   frame_ack     : consumer releases the frame
//   frame_cmd     : CMD byte of the pending frame
//   frame_len     : payload length (0..MAX_LEN)
//   payload_addr  : payload read address
//   payload_data  : buffer[payload_addr], one cycle later
//   err_pulse     : one-cycle error strobe
//   err_code      : error reason, valid with err_pulse
//   dbg_state     : current assembly state (observation only)
// -----------------------------------------------------------------------------
module uart_frame_decoder
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_ready,
   output logic                         frame_valid,
   input  logic                         frame_ack,
   output logic [7:0]                   frame_cmd,
   output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
   input  logic [$clog2(MAX_LEN)-1:0]   payload_addr,
   output logic [7:0]                   payload_data,
   output logic                         err_pulse,
   output logic [1:0]                   err_code,
   output logic [2:0]                   dbg_state
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int AW = $clog2(MAX_LEN);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYCLES - 1);

   state_t         r_state;
   logic [TW-1:0]  r_cnt;
   logic [7:0]     r_chk;
   logic [AW-1:0]  r_idx;
   logic [7:0]     r_cmd;
   logic [LW-1:0]  r_len;
   logic           r_valid;
   logic           r_err_pulse;
   err_code_t      r_err_code;

   logic           w_tmo;
   logic           w_idx_last;
   logic           w_wr_en;

   // Terminal count of the inter-byte timer. A byte strobe in the same cycle
   // takes priority, so the timeout only fires on a silent cycle.
   assign w_tmo      = in_frame(r_state) && !rx_ready && (r_cnt == T_LAST);

   // The byte being written now is the last payload byte.
   assign w_idx_last = (LW'(r_idx) + LW'(1)) == r_len;

   // The buffer is written only while collecting payload, so it stays frozen
   // while a completed frame is pending.
   assign w_wr_en    = rx_ready && (r_state == DATA);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_chk       <= '0;
         r_idx       <= '0;
         r_cmd       <= '0;
         r_len       <= '0;
         r_valid     <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_code  <= ERR_BAD_LEN;
      end else begin
         r_err_pulse <= 1'b0;

         if (rx_ready || !in_frame(r_state)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + TW'(1);
         end

         if (w_tmo) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_err_pulse <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
         end else begin
            case (r_state)
               IDLE: begin
                  if (rx_ready && (rx_data == SYNC_BYTE)) begin
                     r_state <= CMD;
                  end
               end

               CMD: begin
                  if (rx_ready) begin
                     r_cmd   <= rx_data;
                     r_chk   <= rx_data;
                     r_state <= LEN;
                  end
               end

               LEN: begin
                  if (rx_ready) begin
                     if (rx_data > MAX_LEN_B) begin
                        r_state     <= IDLE;
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ERR_BAD_LEN;
                     end else begin
                        r_len   <= LW'(rx_data);
                        r_chk   <= r_chk ^ rx_data;
                        r_idx   <= '0;
                        r_state <= (rx_data == 8'd0) ? CHK : DATA;
                     end
                  end
               end

               DATA: begin
                  if (rx_ready) begin
                     r_chk <= r_chk ^ rx_data;
                     r_idx <= r_idx + AW'(1);
                     if (w_idx_last) begin
                        r_state <= CHK;
                     end
                  end
               end

               CHK: begin
                  if (rx_ready) begin
                     if (rx_data == r_chk) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                     end else begin
                        r_state     <= IDLE;
                        r_err_pulse <= 1'b1;
                        r_err_code  <= ERR_BAD_CHK;
                     end
                  end
               end

               DONE: begin
                  if (frame_ack) begin
                     // Release the frame; a byte arriving with the ack is
                     // treated exactly as if the decoder were already idle.
                     r_valid <= 1'b0;
                     r_state <= (rx_ready && (rx_data == SYNC_BYTE)) ? CMD : IDLE;
                  end else if (rx_ready) begin
                     r_err_pulse <= 1'b1;
                     r_err_code  <= ERR_OVERRUN;
                  end
               end

               default: begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   uart_payload_ram #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_ram (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_idx),
      .i_wr_data (rx_data),
      .i_rd_addr (payload_addr),
      .o_rd_data (payload_data)
   );

   assign frame_valid = r_valid;
   assign frame_cmd   = r_cmd;
   assign frame_len   = r_len;
   assign err_pulse   = r_err_pulse;
   assign err_code    = r_err_code;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_decoder
// Directed scenarios plus randomized frames. Expected outcomes come from a
// frame-level reference: a frame is good when LEN <= MAX_LEN and the XOR of
// CMD, LEN and payload equals CHK; the error code follows from which rule
// failed. Error pulses are collected by a monitor into a queue.
// -----------------------------------------------------------------------------
module tb_uart_frame_decoder;

   localparam int         MAX_LEN = 16;
   localparam int         TMO     = 50;
   localparam int         LW      = $clog2(MAX_LEN + 1);
   localparam int         AW      = $clog2(MAX_LEN);
   localparam logic [7:0] SYNC    = 8'hA5;

   localparam int K_GOOD   = 0;
   localparam int K_BADLEN = 1;
   localparam int K_BADCHK = 2;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          frame_valid;
   logic          frame_ack;
   logic [7:0]    frame_cmd;
   logic [LW-1:0] frame_len;
   logic [AW-1:0] payload_addr;
   logic [7:0]    payload_data;
   logic          err_pulse;
   logic [1:0]    err_code;
   logic [2:0]    dbg_state;

   always #5 clk = ~clk;

   uart_frame_decoder #(
      .SYNC_BYTE      (SYNC),
      .MAX_LEN        (MAX_LEN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .frame_valid  (frame_valid),
      .frame_ack    (frame_ack),
      .frame_cmd    (frame_cmd),
      .frame_len    (frame_len),
      .payload_addr (payload_addr),
      .payload_data (payload_data),
      .err_pulse    (err_pulse),
      .err_code     (err_code),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   logic [1:0] obs_err_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Error monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (err_pulse === 1'b1) obs_err_q.push_back(err_code);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_tx(input int start, input int gmin, input int gmax);
      for (int i = start; i < tx_q.size(); i++) begin
         send_byte(tx_q[i]);
         if (i != tx_q.size() - 1) repeat ($urandom_range(gmin, gmax)) tick();
      end
   endtask

   task automatic build_frame(input logic [7:0] c, input int ln, input bit corrupt);
      logic [7:0] x;
      logic [7:0] p;
      tx_q.delete();
      tx_q.push_back(SYNC);
      tx_q.push_back(c);
      tx_q.push_back(8'(ln));
      if (ln <= MAX_LEN) begin
         x = c ^ 8'(ln);
         for (int i = 0; i < ln; i++) begin
            p = 8'($urandom);
            tx_q.push_back(p);
            x = x ^ p;
         end
         if (corrupt) x = x ^ 8'($urandom_range(1, 255));
         tx_q.push_back(x);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_frame(output int kind, output logic [7:0] m_cmd, output int m_len);
      logic [7:0] x;
      exp_q.delete();
      m_cmd = tx_q[1];
      m_len = int'(tx_q[2]);
      if (m_len > MAX_LEN) begin
         kind = K_BADLEN;
      end else begin
         x = 8'h00;
         for (int i = 1; i < 3 + m_len; i++) x = x ^ tx_q[i];
         if (x == tx_q[3 + m_len]) begin
            kind = K_GOOD;
            for (int i = 0; i < m_len; i++) exp_q.push_back(tx_q[3 + i]);
         end else begin
            kind = K_BADCHK;
         end
      end
   endtask

   task automatic run_frame(input string tag, input int start, input int gmin, input int gmax);
      int         kind;
      logic [7:0] m_cmd;
      int         m_len;
      model_frame(kind, m_cmd, m_len);
      obs_err_q.delete();
      send_tx(start, gmin, gmax);
      if (kind == K_GOOD) begin
         check_eq({tag, " valid"}, frame_valid, 1);
         check_eq({tag, " cmd"}, frame_cmd, m_cmd);
         check_eq({tag, " len"}, frame_len, m_len);
         for (int i = 0; i < m_len; i++) begin
            payload_addr = AW'(i);
            tick();
            check_eq({tag, " payload"}, payload_data, exp_q.pop_front());
         end
         frame_ack = 1'b1;
         tick();
         frame_ack = 1'b0;
         check_eq({tag, " valid_drop"}, frame_valid, 0);
         tick();
         tick();
         check_eq({tag, " no_err"}, obs_err_q.size(), 0);
      end else begin
         check_eq({tag, " no_valid"}, frame_valid, 0);
         tick();
         tick();
         check_eq({tag, " err_cnt"}, obs_err_q.size(), 1);
         check_eq({tag, " err_code"},
                  (obs_err_q.size() > 0) ? 32'(obs_err_q[0]) : 32'hFFFF,
                  (kind == K_BADLEN) ? 32'd0 : 32'd1);
         check_eq({tag, " idle"}, dbg_state, uart_pkg::IDLE);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      reset        = 1'b1;
      rx_data      = 8'h00;
      rx_ready     = 1'b0;
      frame_ack    = 1'b0;
      payload_addr = '0;
      repeat (3) tick();

      // Reset state
      check_eq("rst valid", frame_valid, 0);
      check_eq("rst cmd", frame_cmd, 0);
      check_eq("rst len", frame_len, 0);
      check_eq("rst pdata", payload_data, 0);
      check_eq("rst err", err_pulse, 0);
      check_eq("rst code", err_code, 0);
      reset = 1'b0;
      tick();

      // 1. Good frame
      tx_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72};
      run_frame("t1", 0, 0, 0);

      // 2. Zero length after noise
      send_byte(8'h00);
      send_byte(8'hFF);
      tx_q = '{8'hA5, 8'h07, 8'h00, 8'h07};
      run_frame("t2", 0, 0, 0);

      // 3. Bad checksum, bad length, then a good frame
      tx_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h73};
      run_frame("t3chk", 0, 0, 0);
      tx_q = '{8'hA5, 8'h01, 8'h11};
      run_frame("t3len", 0, 0, 0);
      tx_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72};
      run_frame("t3good", 0, 0, 0);

      // 4. Timeout at the terminal count, one pulse only
      obs_err_q.delete();
      send_byte(8'hA5);
      send_byte(8'h12);
      repeat (TMO - 1) tick();
      check_eq("tmo pre", err_pulse, 0);
      tick();
      check_eq("tmo fire", err_pulse, 1);
      check_eq("tmo code", err_code, 2);
      check_eq("tmo idle", dbg_state, uart_pkg::IDLE);
      tick();
      check_eq("tmo width", err_pulse, 0);
      tick();
      check_eq("tmo count", obs_err_q.size(), 1);

      // 4b. Every byte arrives exactly on the terminal count
      tx_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72};
      run_frame("tmo_edge", 0, TMO - 1, TMO - 1);

      // 5. Overrun while pending, then SYNC together with ack
      tx_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72};
      send_tx(0, 0, 2);
      check_eq("ovr valid", frame_valid, 1);
      obs_err_q.delete();
      send_byte(8'h00);
      check_eq("ovr pulse", err_pulse, 1);
      check_eq("ovr code", err_code, 3);
      check_eq("ovr hold valid", frame_valid, 1);
      check_eq("ovr hold cmd", frame_cmd, 8'h12);
      check_eq("ovr hold len", frame_len, 2);
      payload_addr = 0;
      tick();
      check_eq("ovr pay0", payload_data, 8'h34);
      payload_addr = 1;
      tick();
      check_eq("ovr pay1", payload_data, 8'h56);
      obs_err_q.delete();
      rx_data   = SYNC;
      rx_ready  = 1'b1;
      frame_ack = 1'b1;
      tick();
      rx_ready  = 1'b0;
      frame_ack = 1'b0;
      check_eq("ack_sync valid", frame_valid, 0);
      check_eq("ack_sync state", dbg_state, uart_pkg::CMD);
      check_eq("ack_sync err", err_pulse, 0);
      build_frame(8'h5C, 3, 1'b0);
      run_frame("ack_sync frame", 1, 0, 2);

      // 6. Reset mid-frame
      obs_err_q.delete();
      send_byte(8'hA5);
      send_byte(8'h12);
      send_byte(8'h02);
      send_byte(8'h34);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mid_rst valid", frame_valid, 0);
      check_eq("mid_rst cmd", frame_cmd, 0);
      check_eq("mid_rst len", frame_len, 0);
      check_eq("mid_rst pdata", payload_data, 0);
      check_eq("mid_rst err", err_pulse, 0);
      check_eq("mid_rst code", err_code, 0);
      check_eq("mid_rst state", dbg_state, uart_pkg::IDLE);
      tick();
      tick();
      check_eq("mid_rst no_err", obs_err_q.size(), 0);
      tx_q = '{8'hA5, 8'h12, 8'h02, 8'h34, 8'h56, 8'h72};
      run_frame("mid_rst frame", 0, 0, 0);

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         int         r;
         int         ln;
         int         gmax;
         logic [7:0] c;
         logic [7:0] nb;
         r = $urandom_range(0, 9);
         c = 8'($urandom);
         if (r == 0) ln = $urandom_range(MAX_LEN + 1, 255);
         else        ln = $urandom_range(0, MAX_LEN);
         build_frame(c, ln, (r == 1) || (r == 2));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               nb = 8'($urandom);
               if (nb == SYNC) nb = 8'h00;
               send_byte(nb);
            end
         end
         gmax = ($urandom_range(0, 4) == 0) ? TMO - 1 : 3;
         run_frame("rnd", 0, 0, gmax);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream: rx_data plus a one-clock rx_ready pulse per byte. Assembles bytes into framed commands with the format SYNC, CMD, LEN, LEN payload bytes, CHK. Validates length and XOR checksum, buffers the payload, and presents a completed frame to the application logic through a valid/ack handshake. Reports malformed, timed-out and overrun traffic as one-cycle error pulses with a code.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker.
MAX_LEN, 16, maximum payload bytes; also the buffer depth.
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (about 11 byte times at 115200 baud, 100 MHz).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  received byte; valid only when rx_ready=1.
rx_ready  input  1  single-cycle byte strobe from the receiver.
frame_valid  output  1  completed good frame is pending; held until acked.
frame_ack  input  1  consumer releases the frame; sampled only while frame_valid=1.
frame_cmd  output  8  CMD byte of the pending frame.
frame_len  output  $clog2(MAX_LEN+1)  payload length, 0..MAX_LEN.
payload_addr  input  $clog2(MAX_LEN)  payload read address.
payload_data  output  8  buffer[payload_addr], registered, 1-cycle read latency.
err_pulse  output  1  one-cycle error strobe.
err_code  output  2  reason code, valid with err_pulse: 0=BAD_LEN, 1=BAD_CHK, 2=TIMEOUT, 3=OVERRUN.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; the timeout counter and running checksum clear.
  - All outputs are 0: frame_valid, frame_cmd, frame_len, payload_data, err_pulse, err_code.
  - Buffer contents are don't-care.
  - A reset mid-frame discards the partial frame with no error reported.
- States: IDLE, CMD, LEN, DATA, CHK, DONE. All transitions below occur on rx_ready=1 unless stated otherwise.
- IDLE:
  - rx_data==SYNC_BYTE -> CMD.
  - Any other byte is silently ignored.
- CMD: latch the CMD byte; set chk=rx_data -> LEN.
- LEN:
  - rx_data > MAX_LEN -> err BAD_LEN, go to IDLE.
  - Otherwise latch the length and set chk ^= rx_data.
  - Length 0 -> CHK; non-zero length -> DATA with the write index at 0.
- DATA:
  - Write buffer[idx] = rx_data, set chk ^= rx_data, increment idx.
  - After the byte at idx == len-1 -> CHK.
- CHK:
  - rx_data == chk -> DONE; frame_valid rises the next cycle.
  - Mismatch -> err BAD_CHK, go to IDLE.
- DONE:
  - frame_valid=1; frame_cmd and frame_len are stable; the buffer is not written.
  - frame_ack=1 -> IDLE, and frame_valid=0 the next cycle.
  - rx_ready while in DONE without frame_ack -> byte dropped, err OVERRUN.
  - rx_ready and frame_ack in the same cycle -> the frame is released and the byte is evaluated as in IDLE (SYNC_BYTE -> CMD). No OVERRUN is raised.
- Timeout:
  - The counter clears on every rx_ready and in IDLE/DONE.
  - It increments every cycle in CMD, LEN, DATA and CHK.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_ready that cycle -> err TIMEOUT, go to IDLE.
  - If rx_ready coincides with the terminal count, the byte wins and the counter clears.
- Error outputs: err_pulse and err_code are registered and appear one cycle after the causing event. err_pulse is exactly one cycle wide.
- Payload read: payload_data updates every clock from payload_addr. Addresses >= frame_len return stale or undefined data and are not checked.
- Upstream guarantees rx_ready is one cycle wide. Back-to-back rx_ready on consecutive cycles must be handled.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, CMD, LEN, DATA, CHK, DONE);
  - the err_code enum (ERR_BAD_LEN, ERR_BAD_CHK, ERR_TIMEOUT, ERR_OVERRUN);
  - the default SYNC_BYTE constant.
- One sub-module, uart_payload_ram: MAX_LEN x 8, one write port, one registered read port.

Test Plan:
1. Good frame: A5 12 02 34 56 72 -> frame_valid=1 one cycle after the 0x72 strobe; cmd=0x12, len=2; reading addr 0 then 1 returns 0x34 then 0x56; ack drops valid the next cycle; no err_pulse.
2. Zero length with a noise lead-in: 00 FF A5 07 00 07 -> the leading 00 and FF are ignored; valid with cmd=0x07, len=0.
3. Bad checksum / bad length: A5 12 02 34 56 73 -> err_pulse with code 1, no valid. A5 01 11 -> code 0, back in IDLE; a following good frame is accepted.
4. Timeout: A5 12 then silence for TIMEOUT_CYCLES (test value 50) -> a single err_pulse with code 2. Also check that a byte arriving exactly at the terminal count instead continues the frame.
5. Overrun and simultaneous ack: hold the frame without ack and send 0x00 -> code 3 and the frame is unchanged. Then send A5 coincident with frame_ack -> no error; decoder is in CMD and the next frame completes normally.
6. Reset mid-frame: send A5 12 02 34, assert reset for 1 cycle -> all outputs 0, no error; a following good frame decodes correctly.
